button_updown_counter: RTL
==========================

Name: button_updown_counter

Overview:
- Parametrised successor to the single-button LED counter.
- Takes up to three raw, asynchronous push-button inputs: up, down and clear.
- Each button passes through a synchroniser, a debounce FSM and a single-shot pulse generator.
- The resulting pulses drive a WIDTH-bit up/down counter with selectable wrap or saturate mode. The counter feeds board LEDs or a seven-segment driver at the top level.

Parameters:
- WIDTH, 16, counter and count-output width in bits (2..32).
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser (>=2).
- DEBOUNCE_CYCLES, 500000, clock cycles a synchronised level must be stable before acceptance (>=1; benches use small values).
- SATURATE, 0, 0 = counter wraps modulo 2^WIDTH; 1 = counter holds at max/min.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- btn_up  input  1  raw increment button, asynchronous to clk.
- btn_down  input  1  raw decrement button, asynchronous to clk.
- btn_clr  input  1  raw clear button, asynchronous to clk.
- count  output  WIDTH  current counter value.
- up_pulse  output  1  one-cycle strobe for each accepted up press.
- down_pulse  output  1  one-cycle strobe for each accepted down press.
- at_max  output  1  count == 2^WIDTH-1 (combinational from count).
- at_min  output  1  count == 0 (combinational from count).

Behaviour:
- Reset: on clk edge with rst=1, all synchroniser flops, FSMs and debounce counters clear.
  - count=0, up_pulse=0, down_pulse=0, at_max=0, at_min=1.
  - rst mid-debounce or mid-press aborts: FSM to IDLE, no pulse.
  - A button still held when rst deasserts must be released and re-pressed before it counts.
- Synchroniser: each raw button passes through SYNC_STAGES flops; the synchronised level is s.
- Debounce/one-shot FSM, one instance per button, with a debounce counter of width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE: counter=0. s=1 -> PRESS_WAIT.
  - PRESS_WAIT: counter increments each cycle s=1.
    - s=0 -> IDLE, counter cleared.
    - counter == DEBOUNCE_CYCLES-1 with s=1 -> HELD; pulse asserted for exactly this one cycle.
  - HELD: counter=0. s=0 -> RELEASE_WAIT.
  - RELEASE_WAIT: counter increments each cycle s=0.
    - s=1 -> HELD (glitch, no pulse).
    - counter == DEBOUNCE_CYCLES-1 with s=0 -> IDLE.
  - Latency: the pulse is registered and high in the cycle after the clk edge where s has been 1 for DEBOUNCE_CYCLES consecutive cycles. Raw-to-pulse latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - Holding a button yields exactly one pulse.
- Counter: updates on the edge after the pulse cycle, so count changes one cycle after the pulse. Priority, highest first:
  1. clr_pulse: count <= 0.
  2. up_pulse and down_pulse in the same cycle: no change.
  3. up_pulse alone: count+1. At 2^WIDTH-1 it wraps to 0 (SATURATE=0) or holds (SATURATE=1).
  4. down_pulse alone: count-1. At 0 it wraps to 2^WIDTH-1 (SATURATE=0) or holds (SATURATE=1).
- Arithmetic is unsigned, WIDTH bits; no carry/borrow output.
- up_pulse and down_pulse outputs equal the internal debounced pulses. They assert even when saturation suppresses the count change.

Decomposition:
- Package button_pkg holds:
  - typedef enum logic [1:0] debounce_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - localparam DEFAULT_SYNC_STAGES = 2.
- Sub-module button_debounce_oneshot (params SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, rst, btn, pulse, level). It contains the synchroniser, FSM and debounce counter, and is instanced three times.
- Top level holds only the counter and the flag logic.

Test Plan:
All tests use WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset then clean up-press held 20 cycles -> single up_pulse exactly 6 cycles after raw rise; count 0->1 the following cycle; no second pulse while held.
- Bounce: btn_up high 2 cycles, low 1, high 2, low; then stable high 10 cycles -> no pulse during the bounce; exactly one pulse for the stable press; count=1.
- Wrap, SATURATE=0: 15 up presses -> count=15, at_max=1; one more -> count=0, at_min=1. From 0, one down press -> count=15.
- Saturate, SATURATE=1: 20 up presses -> count holds 15 and up_pulse still asserts. 20 down presses -> count holds 0.
- Simultaneous: from count=5, btn_up and btn_down rise on the same cycle -> both pulses in the same cycle, count stays 5. From count=5, btn_clr together with btn_up -> count=0.
- Reset mid-operation: rst asserted for 1 cycle during PRESS_WAIT with button still held -> no pulse, count=0. Release then re-press -> count=1.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the button-driven up/down counter.
package button_pkg;

    // Per-button debounce / one-shot state.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Width of a counter able to hold 0..cycles inclusive.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce_oneshot.sv
// One raw push-button: synchroniser, debounce FSM and single-shot pulse.
// A press is accepted once the synchronised level has been high for
// DEBOUNCE_CYCLES consecutive cycles; the pulse is registered and lasts one
// cycle. A release must be equally stable before the next press can count.
// After reset the button must be seen released before any press is accepted,
// so a button held through reset never produces a pulse.
module button_debounce_oneshot
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic level
);

    localparam int unsigned CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [FILL_W-1:0]      fill_q;
    logic                   sync_valid;
    logic                   armed_q;

    debounce_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cnt_last;
    logic                   pulse_q, pulse_d;

    // Synchroniser chain; bit 0 samples the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Count chain refill after reset; until full, s is reset debris, not the button.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if (!sync_valid) begin
            fill_q <= fill_q + FILL_W'(1);
        end
    end

    assign sync_valid = (fill_q == FILL_FULL);

    // Arm once a genuine released level is observed after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else if (sync_valid && !s) begin
            armed_q <= 1'b1;
        end
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    // FSM state, debounce counter and pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: cnt_q counts prior stable cycles (0 in IDLE/HELD), so the
    // cycle with cnt_q == DEBOUNCE_CYCLES-1 is the last one needed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s && armed_q) begin
                    if (cnt_last) begin
                        state_d = HELD;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!s) begin
                    if (cnt_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    // Release glitch: back to held without a new pulse.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pulse = pulse_q;
    assign level = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/button_updown_counter.sv
// Up/down/clear counter driven by three debounced push-buttons.
// Counter wraps modulo 2^WIDTH, or saturates at the ends when SATURATE != 0.
module button_updown_counter
    import button_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SATURATE        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    logic             up_strobe, down_strobe, clr_strobe;
    logic             up_level, down_level, clr_level;
    logic             unused_levels;
    logic [WIDTH-1:0] count_q, count_d;

    button_debounce_oneshot #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .pulse (up_strobe),
        .level (up_level)
    );

    button_debounce_oneshot #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_down),
        .pulse (down_strobe),
        .level (down_level)
    );

    button_debounce_oneshot #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .pulse (clr_strobe),
        .level (clr_level)
    );

    // Debounced levels are not needed by the counter itself.
    assign unused_levels = ^{up_level, down_level, clr_level};

    // Next count: clear wins, opposing presses cancel, else step with wrap/saturate.
    always_comb begin
        count_d = count_q;
        if (clr_strobe) begin
            count_d = '0;
        end else if (up_strobe && down_strobe) begin
            count_d = count_q;
        end else if (up_strobe) begin
            if ((SATURATE != 0) && (count_q == COUNT_MAX)) begin
                count_d = count_q;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (down_strobe) begin
            if ((SATURATE != 0) && (count_q == '0)) begin
                count_d = count_q;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign up_pulse   = up_strobe;
    assign down_pulse = down_strobe;
    assign at_max     = (count_q == COUNT_MAX);
    assign at_min     = (count_q == '0);

endmodule
